// File: rtl/odesa_pattern_gen.sv
// Spike-pattern sequencer for the ODESA level-1 inputs: two-half channel sweeps
// with a supervised label on the final spike, repeated a configurable number of times.
module odesa_pattern_gen #(
  parameter int p_channels = 8,
  parameter int p_label_w  = 4,
  parameter int p_cnt_w    = 16,
  parameter int p_rep_w    = 10
) (
  input  logic                  i_clk_l1,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [1:0]            i_mode,
  input  logic [p_label_w-1:0]  i_label,
  input  logic [p_cnt_w-1:0]    i_spl,
  input  logic [p_cnt_w-1:0]    i_dlt,
  input  logic [p_cnt_w-1:0]    i_delay,
  input  logic [p_cnt_w-1:0]    i_wait,
  input  logic [p_rep_w-1:0]    i_reps,
  output logic [p_channels-1:0] o_event,
  output logic [p_label_w-1:0]  o_label,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [p_rep_w-1:0]    o_pattern_cnt
);

  // state    | meaning
  // st_idle  | waiting for i_start, outputs quiet
  // st_spike | one-hot event on current channel for max(spl,1) cycles
  // st_gap   | silence between spikes of the same half (dlt cycles)
  // st_delay | silence between the two halves
  // st_label | label held after the final spike, no event
  // st_wait  | silence after the label before the next pattern
  typedef enum logic [2:0] {
    st_idle, st_spike, st_gap, st_delay, st_label, st_wait
  } state_t;

  localparam int ch_w = (p_channels > 1) ? $clog2(p_channels) : 1;
  localparam logic [ch_w-1:0] ch_hi = ch_w'(p_channels - 1);

  state_t               state;
  logic [p_cnt_w-1:0]   timer;
  logic [ch_w-1:0]      ch;
  logic                 half;
  logic [1:0]           mode_q;
  logic [p_label_w-1:0] label_q;
  logic [p_cnt_w-1:0]   spike_ld;
  logic [p_cnt_w-1:0]   dlt_q;
  logic [p_cnt_w-1:0]   delay_q;
  logic [p_cnt_w-1:0]   wait_q;
  logic [p_rep_w-1:0]   reps_q;

  logic                 dir;
  logic [ch_w-1:0]      ch_last;
  logic [ch_w-1:0]      ch_step;
  logic [ch_w-1:0]      ch_first_h0;
  logic [ch_w-1:0]      ch_first_h1;
  logic [ch_w-1:0]      ch_first_start;
  logic                 is_last;
  logic [p_rep_w-1:0]   cnt_inc;
  logic                 run_end;
  logic                 pattern_end;

  function automatic logic [p_channels-1:0] onehot(input logic [ch_w-1:0] c);
    return {{(p_channels-1){1'b0}}, 1'b1} << c;
  endfunction

  always_comb begin
    dir            = half ? mode_q[1] : mode_q[0];
    ch_last        = dir ? '0 : ch_hi;
    ch_step        = dir ? ch - 1'b1 : ch + 1'b1;
    is_last        = (ch == ch_last);
    ch_first_h0    = mode_q[0] ? ch_hi : '0;
    ch_first_h1    = mode_q[1] ? ch_hi : '0;
    ch_first_start = i_mode[0] ? ch_hi : '0;
    cnt_inc        = o_pattern_cnt + 1'b1;
    run_end        = (reps_q != '0) && (cnt_inc == reps_q);
    pattern_end    = (timer == '0) &&
                     ((state == st_wait) || ((state == st_label) && (wait_q == '0)));
  end

  always_ff @(posedge i_clk_l1) begin
    o_done <= 1'b0;
    if (i_rst) begin
      state         <= st_idle;
      timer         <= '0;
      ch            <= '0;
      half          <= 1'b0;
      mode_q        <= '0;
      label_q       <= '0;
      spike_ld      <= '0;
      dlt_q         <= '0;
      delay_q       <= '0;
      wait_q        <= '0;
      reps_q        <= '0;
      o_event       <= '0;
      o_label       <= '0;
      o_busy        <= 1'b0;
      o_pattern_cnt <= '0;
    end else if (i_stop) begin
      state   <= st_idle;
      timer   <= '0;
      o_event <= '0;
      o_label <= '0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (i_start) begin
            mode_q        <= i_mode;
            label_q       <= i_label;
            spike_ld      <= (i_spl == '0) ? '0 : i_spl - 1'b1;
            timer         <= (i_spl == '0) ? '0 : i_spl - 1'b1;
            dlt_q         <= i_dlt;
            delay_q       <= i_delay;
            wait_q        <= i_wait;
            reps_q        <= i_reps;
            ch            <= ch_first_start;
            half          <= 1'b0;
            o_event       <= onehot(ch_first_start);
            o_label       <= '0;
            o_busy        <= 1'b1;
            o_pattern_cnt <= '0;
            state         <= st_spike;
          end
        end
        st_spike: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (is_last && !half) begin
            half <= 1'b1;
            ch   <= ch_first_h1;
            if (delay_q != '0) begin
              state   <= st_delay;
              timer   <= delay_q - 1'b1;
              o_event <= '0;
            end else begin
              timer   <= spike_ld;
              o_event <= onehot(ch_first_h1);
            end
          end else if (is_last) begin
            state   <= st_label;
            timer   <= spike_ld;
            o_event <= '0;
          end else begin
            ch <= ch_step;
            if (dlt_q != '0) begin
              state   <= st_gap;
              timer   <= dlt_q - 1'b1;
              o_event <= '0;
            end else begin
              timer   <= spike_ld;
              o_event <= onehot(ch_step);
              if (half && (ch_step == ch_last)) o_label <= label_q;
            end
          end
        end
        // ch was already advanced when the gap was entered
        st_gap: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state   <= st_spike;
            timer   <= spike_ld;
            o_event <= onehot(ch);
            if (half && is_last) o_label <= label_q;
          end
        end
        st_delay: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state   <= st_spike;
            timer   <= spike_ld;
            o_event <= onehot(ch);
          end
        end
        st_label: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            o_label <= '0;
            if (wait_q != '0) begin
              state <= st_wait;
              timer <= wait_q - 1'b1;
            end
          end
        end
        st_wait: begin
          if (timer != '0) timer <= timer - 1'b1;
        end
        default: begin
          state   <= st_idle;
          o_event <= '0;
          o_label <= '0;
          o_busy  <= 1'b0;
        end
      endcase

      // Shared exit from LABEL (zero wait) and WAIT; overrides the case above.
      if (pattern_end) begin
        o_pattern_cnt <= cnt_inc;
        if (run_end) begin
          state  <= st_idle;
          timer  <= '0;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end else begin
          state   <= st_spike;
          half    <= 1'b0;
          ch      <= ch_first_h0;
          timer   <= spike_ld;
          o_event <= onehot(ch_first_h0);
        end
      end
    end
  end

endmodule

// File: tb/tb_odesa_pattern_gen.sv
// Directed bench for odesa_pattern_gen: expected per-cycle outputs are queued
// when a run is started and compared cycle by cycle as the DUT plays them out.
module tb_odesa_pattern_gen;

  localparam int n_ch = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [3:0]  label;
  logic [15:0] spl, dlt, dly, wt;
  logic [9:0]  reps;
  logic [7:0]  ev;
  logic [3:0]  lbl;
  logic        busy, done;
  logic [9:0]  pcnt;

  odesa_pattern_gen dut (
    .i_clk_l1(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_mode(mode), .i_label(label), .i_spl(spl), .i_dlt(dlt),
    .i_delay(dly), .i_wait(wt), .i_reps(reps),
    .o_event(ev), .o_label(lbl), .o_busy(busy), .o_done(done),
    .o_pattern_cnt(pcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ev;
    logic [3:0] lbl;
    logic [9:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] e, input logic [3:0] l, input logic [9:0] c);
    exp_t x;
    x.ev = e; x.lbl = l; x.cnt = c;
    q.push_back(x);
  endtask

  // Builds one pattern straight from the sweep description.
  task automatic push_pattern(input logic [1:0] m, input int s_in, input int g, input int d,
                              input int w, input logic [3:0] l, input logic [9:0] c);
    int s;
    int chn;
    logic [7:0] one;
    one = 8'h01;
    s = (s_in == 0) ? 1 : s_in;
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < n_ch; k++) begin
        chn = m[h] ? (n_ch - 1 - k) : k;
        for (int i = 0; i < s; i++)
          push(one << chn, (h == 1 && k == n_ch - 1) ? l : 4'h0, c);
        if (k < n_ch - 1)
          for (int i = 0; i < g; i++) push(8'h00, 4'h0, c);
      end
      if (h == 0)
        for (int i = 0; i < d; i++) push(8'h00, 4'h0, c);
    end
    for (int i = 0; i < s; i++) push(8'h00, l, c);
    for (int i = 0; i < w; i++) push(8'h00, 4'h0, c);
  endtask

  task automatic start_run(input logic [1:0] m, input int s, input int g, input int d,
                           input int w, input int r, input logic [3:0] l);
    mode = m; spl = 16'(s); dlt = 16'(g); dly = 16'(d); wt = 16'(w);
    reps = 10'(r); label = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Compares n queued cycles (all when n < 0), advancing one clock after each.
  task automatic run_stream(input string tag, input int n);
    exp_t e;
    int   k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      e = q.pop_front();
      check($sformatf("%s ev c%0d", tag, k + 1), 32'(ev), 32'(e.ev));
      check($sformatf("%s lbl c%0d", tag, k + 1), 32'(lbl), 32'(e.lbl));
      check($sformatf("%s cnt c%0d", tag, k + 1), 32'(pcnt), 32'(e.cnt));
      check($sformatf("%s busy c%0d", tag, k + 1), 32'(busy), 32'd1);
      check($sformatf("%s done c%0d", tag, k + 1), 32'(done), 32'd0);
      k++;
      if (q.size() > 0 && (n < 0 || k < n)) tick();
    end
  endtask

  task automatic check_done(input string tag, input int cnt);
    tick();
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " cnt"}, 32'(pcnt), 32'(cnt));
    check({tag, " ev"}, 32'(ev), 32'd0);
    tick();
    check({tag, " done clr"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = '0; label = '0;
    spl = '0; dlt = '0; dly = '0; wt = '0; reps = '0;
    tick(); tick();
    check("rst ev", 32'(ev), 0);
    check("rst lbl", 32'(lbl), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst cnt", 32'(pcnt), 0);
    rst = 1'b0;
    tick();

    // up-up reference pattern
    push_pattern(2'b00, 2, 3, 4, 5, 4'hA, 10'd0);
    start_run(2'b00, 2, 3, 4, 5, 1, 4'hA);
    run_stream("upup", -1);
    check_done("upup", 1);

    // direction modes
    push_pattern(2'b10, 1, 1, 2, 1, 4'h6, 10'd0);
    start_run(2'b10, 1, 1, 2, 1, 1, 4'h6);
    run_stream("m10", -1);
    check_done("m10", 1);

    push_pattern(2'b01, 3, 0, 1, 0, 4'h9, 10'd0);
    start_run(2'b01, 3, 0, 1, 0, 1, 4'h9);
    run_stream("m01", -1);
    check_done("m01", 1);

    // zero fields, three back-to-back patterns
    for (int p = 0; p < 3; p++) push_pattern(2'b11, 0, 0, 0, 0, 4'hF, 10'(p));
    check("zero len", q.size(), 51);
    start_run(2'b11, 0, 0, 0, 0, 3, 4'hF);
    run_stream("zero3", -1);
    check_done("zero3", 3);

    // start and config changes while busy are ignored
    for (int p = 0; p < 2; p++) push_pattern(2'b00, 0, 1, 0, 2, 4'h5, 10'(p));
    start_run(2'b00, 0, 1, 0, 2, 2, 4'h5);
    start = 1'b1; mode = 2'b11; spl = 16'd7; dlt = 16'd0; reps = 10'd1; label = 4'h2;
    run_stream("mask", -1);
    start = 1'b0;
    check_done("mask", 2);

    // abort during the fifth spike of the second pattern
    for (int p = 0; p < 2; p++) push_pattern(2'b00, 2, 1, 0, 0, 4'h3, 10'(p));
    start_run(2'b00, 2, 1, 0, 0, 0, 4'h3);
    run_stream("abort", 48 + 13);
    check("abort pre ev", 32'(ev), 32'h10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    q.delete();
    check("abort ev", 32'(ev), 0);
    check("abort lbl", 32'(lbl), 0);
    check("abort busy", 32'(busy), 0);
    check("abort cnt", 32'(pcnt), 1);
    for (int i = 0; i < 3; i++) begin
      check("abort done", 32'(done), 0);
      tick();
    end

    // restart after abort
    push_pattern(2'b00, 0, 0, 0, 0, 4'h1, 10'd0);
    start_run(2'b00, 0, 0, 0, 0, 1, 4'h1);
    run_stream("restart", -1);
    check_done("restart", 1);

    // reset during LABEL
    push_pattern(2'b00, 0, 0, 0, 0, 4'h7, 10'd0);
    start_run(2'b00, 0, 0, 0, 3, 1, 4'h7);
    run_stream("rstlbl", 17);
    check("rstlbl lbl pre", 32'(lbl), 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    check("rstlbl ev", 32'(ev), 0);
    check("rstlbl lbl", 32'(lbl), 0);
    check("rstlbl busy", 32'(busy), 0);
    check("rstlbl done", 32'(done), 0);
    check("rstlbl cnt", 32'(pcnt), 0);
    tick();
    check("rstlbl stay", 32'(busy), 0);

    // start together with stop in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss busy", 32'(busy), 0);
    check("ss ev", 32'(ev), 0);
    tick();
    check("ss stay", 32'(busy), 0);

    // endless run wrapping the pattern counter
    for (int p = 0; p < 1025; p++) push_pattern(2'b00, 0, 0, 0, 0, 4'hC, 10'(p));
    start_run(2'b00, 0, 0, 0, 0, 0, 4'hC);
    run_stream("wrap", -1);
    tick();
    check("wrap cnt", 32'(pcnt), 1);
    check("wrap busy", 32'(busy), 1);
    check("wrap ev", 32'(ev), 32'h01);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("wrap stop", 32'(busy), 0);
    check("wrap nodone", 32'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
